// File: rtl/dmem_burst_ctrl.sv
// Data-memory controller: serializes cache line fills (4-beat read bursts) and
// single-word write-throughs onto a synchronous SRAM after a fixed access latency.
module dmem_burst_ctrl #(
  parameter int ACCESS_LAT = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wen_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [1:0]        rsp_beat_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_last_o,
  output logic              wr_done_o,
  output logic              m_csn_o,
  output logic              m_wen_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_do_o,
  input  logic [DATA_W-1:0] m_di_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_RBURST = 3'd2;
  localparam logic [2:0] S_RLAST  = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        beat_q, beat_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_last_q, wr_done_q;
  logic [1:0]        rsp_beat_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          rd_d    = req_wen_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = 4'(ACCESS_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          beat_d  = 2'd0;
          state_d = rd_q ? S_RBURST : S_WRITE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RBURST: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = S_RLAST;
      end
      S_RLAST: state_d = S_IDLE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response flags trail the SRAM issue by one cycle, matching SRAM read latency.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_beat_q  <= '0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= (state_q == S_RBURST);
      rsp_beat_q  <= (state_q == S_RBURST) ? beat_q : 2'd0;
      rsp_last_q  <= (state_q == S_RBURST) && (beat_q == 2'd3);
      wr_done_q   <= (state_q == S_WRITE);
    end
  end

  assign req_ready_o = rstn_i && (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_beat_o  = rsp_beat_q;
  assign rsp_last_o  = rsp_last_q;
  assign rsp_data_o  = rsp_valid_q ? m_di_i : '0;
  assign wr_done_o   = wr_done_q;

  // Burst addresses stay inside the latched line; the word offset is replaced.
  assign m_csn_o  = !((state_q == S_RBURST) || (state_q == S_WRITE));
  assign m_wen_o  = (state_q != S_WRITE);
  assign m_addr_o = (state_q == S_RBURST) ? {addr_q[ADDR_W-1:2], beat_q} :
                    (state_q == S_WRITE)  ? addr_q : '0;
  assign m_do_o   = (state_q == S_WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_burst_ctrl.sv
// Scoreboard bench for dmem_burst_ctrl: two instances (latency 4 and 1), each with
// an SRAM model preloaded with word a = a*3.
module tb_dmem_burst_ctrl;

  typedef struct {
    int          inst;
    int          cyc;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  beat;
    logic        last;
  } ev_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen   [2];
  logic [11:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [1:0]  rsp_beat  [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_last  [2];
  logic        wr_done   [2];
  logic        m_csn     [2];
  logic        m_wen     [2];
  logic [11:0] m_addr    [2];
  logic [31:0] m_do      [2];
  logic [31:0] m_di      [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t rspq[$];
  ev_t memq[$];
  logic [31:0] wmem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_burst_ctrl #(.ACCESS_LAT(4), .ADDR_W(12), .DATA_W(32)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_wen_i(req_wen[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_beat_o(rsp_beat[0]), .rsp_data_o(rsp_data[0]),
    .rsp_last_o(rsp_last[0]), .wr_done_o(wr_done[0]),
    .m_csn_o(m_csn[0]), .m_wen_o(m_wen[0]), .m_addr_o(m_addr[0]), .m_do_o(m_do[0]),
    .m_di_i(m_di[0]));

  dmem_burst_ctrl #(.ACCESS_LAT(1), .ADDR_W(12), .DATA_W(32)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_wen_i(req_wen[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_beat_o(rsp_beat[1]), .rsp_data_o(rsp_data[1]),
    .rsp_last_o(rsp_last[1]), .wr_done_o(wr_done[1]),
    .m_csn_o(m_csn[1]), .m_wen_o(m_wen[1]), .m_addr_o(m_addr[1]), .m_do_o(m_do[1]),
    .m_di_i(m_di[1]));

  // SRAM models: unwritten words read as address*3
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_csn[i] === 1'b0) begin
        if (m_wen[i] === 1'b0) wmem[i*4096 + int'(m_addr[i])] = m_do[i];
        else if (wmem.exists(i*4096 + int'(m_addr[i]))) m_di[i] <= wmem[i*4096 + int'(m_addr[i])];
        else m_di[i] <= 32'(m_addr[i]) * 32'd3;
      end
    end
  end

  // Monitor: every DUT output event is matched against the scoreboard queues
  always @(negedge clk) begin
    ev_t  e;
    logic ok;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid[i] === 1'b1 || wr_done[i] === 1'b1) begin
        checks++;
        if (rspq.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected inst=%0d cyc=%0d valid=%b done=%b beat=%0d data=%h",
                   i, cyc, rsp_valid[i], wr_done[i], rsp_beat[i], rsp_data[i]);
        end else begin
          e  = rspq.pop_front();
          ok = (e.inst == i) && (e.cyc == cyc) && (wr_done[i] === e.wr) && (rsp_valid[i] === !e.wr) &&
               (e.wr || (rsp_beat[i] === e.beat && rsp_data[i] === e.data && rsp_last[i] === e.last));
          if (!ok) begin
            errors++;
            $display("FAIL rsp inst=%0d cyc=%0d got done=%b beat=%0d data=%h last=%b; exp inst=%0d cyc=%0d done=%b beat=%0d data=%h last=%b",
                     i, cyc, wr_done[i], rsp_beat[i], rsp_data[i], rsp_last[i],
                     e.inst, e.cyc, e.wr, e.beat, e.data, e.last);
          end
        end
      end
      if (m_csn[i] === 1'b0) begin
        checks++;
        if (memq.size() == 0) begin
          errors++;
          $display("FAIL sram_unexpected inst=%0d cyc=%0d wen=%b addr=%h do=%h",
                   i, cyc, m_wen[i], m_addr[i], m_do[i]);
        end else begin
          e  = memq.pop_front();
          ok = (e.inst == i) && (e.cyc == cyc) && (m_wen[i] === !e.wr) && (m_addr[i] === e.addr) &&
               (!e.wr || m_do[i] === e.data);
          if (!ok) begin
            errors++;
            $display("FAIL sram inst=%0d cyc=%0d got wen=%b addr=%h do=%h; exp inst=%0d cyc=%0d wr=%b addr=%h do=%h",
                     i, cyc, m_wen[i], m_addr[i], m_do[i], e.inst, e.cyc, e.wr, e.addr, e.data);
          end
        end
      end else begin
        checks++;
        if (m_csn[i] !== 1'b1 || m_wen[i] !== 1'b1 || m_addr[i] !== 12'h0 || m_do[i] !== 32'h0 ||
            (rsp_valid[i] !== 1'b1 && rsp_last[i] !== 1'b0)) begin
          errors++;
          $display("FAIL idle inst=%0d cyc=%0d got csn=%b wen=%b addr=%h do=%h last=%b; exp 1 1 000 0 0",
                   i, cyc, m_csn[i], m_wen[i], m_addr[i], m_do[i], rsp_last[i]);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic exp_mem(input int i, input int c, input logic wr, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    e.inst = i; e.cyc = c; e.wr = wr; e.addr = a; e.data = d; e.beat = 2'd0; e.last = 1'b0;
    memq.push_back(e);
  endtask

  task automatic exp_rsp(input int i, input int c, input logic wr, input logic [1:0] b,
                         input logic [31:0] d, input logic l);
    ev_t e;
    e.inst = i; e.cyc = c; e.wr = wr; e.addr = 12'h0; e.data = d; e.beat = b; e.last = l;
    rspq.push_back(e);
  endtask

  // Read accepted in cycle c with latency l: nm SRAM issues and nr beats expected
  task automatic exp_read(input int i, input int c, input int l, input logic [11:0] base,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] d3, input int nm, input int nr);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int b = 0; b < nm; b++) exp_mem(i, c + l + 1 + b, 1'b0, {base[11:2], 2'(b)}, 32'h0);
    for (int b = 0; b < nr; b++) exp_rsp(i, c + l + 2 + b, 1'b0, 2'(b), d[b], b == 3);
  endtask

  // Called at a negedge; returns the cycle whose closing edge accepted the request
  task automatic issue(input int i, input logic rd, input logic [11:0] a, input logic [31:0] d,
                       output int acc);
    req_wen[i] = rd; req_addr[i] = a; req_wdata[i] = d; req_valid[i] = 1'b1;
    acc = -1;
    for (int k = 0; k < 64; k++) begin
      if (req_ready[i] === 1'b1) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout inst=%0d addr=%h got no REQ_READY exp REQ_READY", i, a);
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && (rspq.size() != 0 || memq.size() != 0); k++) @(negedge clk);
    checks++;
    if (rspq.size() != 0 || memq.size() != 0) begin
      errors++;
      $display("FAIL drain got rsp_pending=%0d sram_pending=%0d exp 0 0", rspq.size(), memq.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc2;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b1; req_wen[i] = 1'b1; req_addr[i] = 12'h0; req_wdata[i] = 32'h0;
    end

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_ready0", 32'(req_ready[0]), 32'h0);
      chk("rst_ready1", 32'(req_ready[1]), 32'h0);
      chk("rst_csn", 32'(m_csn[0]), 32'h1);
      chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
      chk("rst_wr_done", 32'(wr_done[0]), 32'h0);
    end
    rstn = 1'b1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    #1 chk("ready_after_rst", 32'(req_ready[0]), 32'h1);
    @(negedge clk);

    // Line fill of 0x123: beats always start at the line base
    issue(0, 1'b1, 12'h123, 32'h0, acc);
    exp_read(0, acc, 4, 12'h120, 32'h360, 32'h363, 32'h366, 32'h369, 4, 4);
    to_cyc(acc + 9);
    chk("ready_during_rlast", 32'(req_ready[0]), 32'h0);
    @(negedge clk);
    chk("ready_after_fill", 32'(req_ready[0]), 32'h1);
    drain();

    // Write-through, inputs scrambled after accept, then read-back in the WR_DONE cycle
    issue(0, 1'b0, 12'h045, 32'hDEADBEEF, acc);
    req_addr[0] = 12'hFFF; req_wdata[0] = 32'h12345678;
    exp_mem(0, acc + 5, 1'b1, 12'h045, 32'hDEADBEEF);
    exp_rsp(0, acc + 6, 1'b1, 2'd0, 32'h0, 1'b0);
    issue(0, 1'b1, 12'h044, 32'h0, acc2);
    chk("rd_after_wr_accept", 32'(acc2), 32'(acc + 6));
    exp_read(0, acc2, 4, 12'h044, 32'h0CC, 32'hDEADBEEF, 32'h0D2, 32'h0D5, 4, 4);
    drain();

    // Busy: request for 0x200 held during a burst is taken exactly once, when idle
    issue(0, 1'b1, 12'h088, 32'h0, acc);
    exp_read(0, acc, 4, 12'h088, 32'h198, 32'h19B, 32'h19E, 32'h1A1, 4, 4);
    issue(0, 1'b1, 12'h200, 32'h0, acc2);
    chk("busy_accept_cycle", 32'(acc2), 32'(acc + 10));
    exp_read(0, acc2, 4, 12'h200, 32'h600, 32'h603, 32'h606, 32'h609, 4, 4);
    drain();

    // Reset at the cycle-7 edge abandons the burst after beat 1 was issued
    issue(0, 1'b1, 12'h120, 32'h0, acc);
    exp_read(0, acc, 4, 12'h120, 32'h360, 32'h363, 32'h366, 32'h369, 2, 1);
    to_cyc(acc + 6);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_csn", 32'(m_csn[0]), 32'h1);
    chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("midrst_ready", 32'(req_ready[0]), 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    chk("postrst_csn", 32'(m_csn[0]), 32'h1);
    chk("postrst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    drain();
    issue(0, 1'b1, 12'h120, 32'h0, acc);
    exp_read(0, acc, 4, 12'h120, 32'h360, 32'h363, 32'h366, 32'h369, 4, 4);
    drain();

    // Latency 1, back-to-back read then held write, then read-back from offset 3
    issue(1, 1'b1, 12'h010, 32'h0, acc);
    exp_read(1, acc, 1, 12'h010, 32'h030, 32'h033, 32'h036, 32'h039, 4, 4);
    issue(1, 1'b0, 12'h011, 32'h00005A5A, acc2);
    chk("l1_write_accept", 32'(acc2), 32'(acc + 7));
    exp_mem(1, acc + 9, 1'b1, 12'h011, 32'h00005A5A);
    exp_rsp(1, acc + 10, 1'b1, 2'd0, 32'h0, 1'b0);
    issue(1, 1'b1, 12'h013, 32'h0, acc);
    exp_read(1, acc, 1, 12'h010, 32'h030, 32'h00005A5A, 32'h036, 32'h039, 4, 4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
